// File: rtl/gf16_sqscmul_sched.sv
// gf16_sqscmul_sched: sequencer for the masked GF(2^4) square-scale-multiply
// stage of the 2-share TI S-box.
//
// Ports:
//   clk, rst_n               clock, async active-low reset
//   flush                    sync clear of both pipeline valids
//   in_valid/in_ready        operand handshake (in_tag, in00/in01, in10/in11)
//   rnd_valid/rnd_ready      PRNG word handshake (rnd_data: [3:0]=r0, [7:4]=r1)
//   out_valid/out_ready      result handshake (out_tag, out0/out1)
//   starve_cnt               saturating count of randomness-starved cycles
//   busy                     any stage valid or operand pending
//
// GF(2^4) is polynomial basis mod x^4+x+1; SqSc(x) = NU * x^2.
module gf16_sqscmul_sched #(
    parameter int RND_DEPTH = 2,
    parameter int TAG_W     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [TAG_W-1:0] in_tag,
    input  logic [3:0]       in00,
    input  logic [3:0]       in01,
    input  logic [3:0]       in10,
    input  logic [3:0]       in11,
    input  logic             rnd_valid,
    output logic             rnd_ready,
    input  logic [7:0]       rnd_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [TAG_W-1:0] out_tag,
    output logic [3:0]       out0,
    output logic [3:0]       out1,
    output logic [15:0]      starve_cnt,
    output logic             busy
);

    localparam int PW = $clog2(RND_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [3:0] NU = 4'h9;

    function automatic logic [3:0] gmul(input logic [3:0] a, input logic [3:0] b);
        logic [6:0] p;
        p = '0;
        for (int i = 0; i < 4; i++) begin
            if (a[i]) p = p ^ ({3'b000, b} << i);
        end
        // x^4 = x+1, x^5 = x^2+x, x^6 = x^3+x^2
        return {p[3] ^ p[6],
                p[2] ^ p[5] ^ p[6],
                p[1] ^ p[4] ^ p[5],
                p[0] ^ p[4]};
    endfunction

    function automatic logic [3:0] sqsc(input logic [3:0] x);
        return gmul(NU, gmul(x, x));
    endfunction

    // Randomness FIFO
    logic [7:0]    mem [RND_DEPTH];
    logic [PW-1:0] wp, rp;
    logic [CW-1:0] cnt;
    logic          full, empty, push, accept;
    logic [3:0]    r0, r1;

    // Pipeline state
    logic             s1v;
    logic [3:0]       s1_0, s1_1, s1_2, s1_3;
    logic [TAG_W-1:0] s1_tag;
    logic             adv1, adv2;
    logic [3:0]       c0, c1, c2, c3;

    assign full      = (cnt == CW'(RND_DEPTH));
    assign empty     = (cnt == '0);
    assign rnd_ready = !full;
    assign push      = rnd_valid && !full;

    assign adv2     = !out_valid || out_ready;
    assign adv1     = !s1v || adv2;
    assign in_ready = !empty && adv1 && !flush;
    assign accept   = in_valid && in_ready;
    assign busy     = s1v | out_valid | in_valid;

    assign r0 = mem[rp][3:0];
    assign r1 = mem[rp][7:4];

    // Each share mixes at most one share index of each operand, so the
    // in0/in1 share pairs are only recombined after S1. SqSc is GF(2)-linear,
    // hence SqSc(a0^b0) ^ SqSc(a1^b1) = SqSc(in0^in1). The mask is arranged
    // so s1_0^s1_1 and s1_2^s1_3 each carry r1, cancelling in out0^out1.
    assign c0 = gmul(in00, in10) ^ sqsc(in00 ^ in10) ^ r0;
    assign c1 = gmul(in00, in11) ^ r0 ^ r1;
    assign c2 = gmul(in01, in10) ^ r0;
    assign c3 = gmul(in01, in11) ^ sqsc(in01 ^ in11) ^ r0 ^ r1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
            for (int i = 0; i < RND_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wp] <= rnd_data;
                wp      <= wp + PW'(1);
            end
            if (accept) rp <= rp + PW'(1);
            cnt <= cnt + CW'(push) - CW'(accept);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1v    <= 1'b0;
            s1_0   <= '0;
            s1_1   <= '0;
            s1_2   <= '0;
            s1_3   <= '0;
            s1_tag <= '0;
        end else if (flush) begin
            s1v <= 1'b0;
        end else if (accept) begin
            s1v    <= 1'b1;
            s1_0   <= c0;
            s1_1   <= c1;
            s1_2   <= c2;
            s1_3   <= c3;
            s1_tag <= in_tag;
        end else if (adv2) begin
            s1v <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out0      <= '0;
            out1      <= '0;
            out_tag   <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (adv2 && s1v) begin
            out_valid <= 1'b1;
            out0      <= s1_0 ^ s1_1;
            out1      <= s1_2 ^ s1_3;
            out_tag   <= s1_tag;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (in_valid && empty && adv1 && !flush
                     && starve_cnt != 16'hFFFF) begin
            starve_cnt <= starve_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_gf16_sqscmul_sched.sv
// tb_gf16_sqscmul_sched: randomized self-checking bench with a queue-based
// reference model of the randomness FIFO and result stream.
module tb_gf16_sqscmul_sched;

    localparam int TW = 4;
    localparam int D  = 2;

    logic          clk = 1'b0;
    logic          rst_n, flush, in_valid, in_ready;
    logic [TW-1:0] in_tag, out_tag;
    logic [3:0]    in00, in01, in10, in11, out0, out1;
    logic          rnd_valid, rnd_ready, out_valid, out_ready, busy;
    logic [7:0]    rnd_data;
    logic [15:0]   starve_cnt;

    int n_chk = 0;
    int n_fail = 0;
    int rnd_mode = 0;
    int cycle = 0;

    typedef struct {
        logic [TW-1:0] tag;
        logic [3:0]    v;
        bit            z;
        logic [3:0]    r1;
    } exp_t;

    logic [7:0] rq[$];
    exp_t       eq[$];

    gf16_sqscmul_sched #(.RND_DEPTH(D), .TAG_W(TW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_tag(in_tag),
        .in00(in00), .in01(in01), .in10(in10), .in11(in11),
        .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .rnd_data(rnd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
        .out0(out0), .out1(out1), .starve_cnt(starve_cnt), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, a, e, $time);
        end
    endtask

    // Shift-and-add multiply, reduced by x^4+x+1
    function automatic logic [3:0] gm(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] r = 4'h0;
        logic [3:0] aa = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) r = r ^ aa;
            aa = aa[3] ? ({aa[2:0], 1'b0} ^ 4'b0011) : {aa[2:0], 1'b0};
        end
        return r;
    endfunction

    function automatic logic [3:0] golden(input logic [3:0] a, input logic [3:0] b);
        return gm(a, b) ^ gm(4'h9, gm(a ^ b, a ^ b));
    endfunction

    // PRNG source
    always @(posedge clk) begin
        #1;
        case (rnd_mode)
            1: begin rnd_valid = 1'b1; rnd_data = 8'($urandom); end
            2: begin rnd_valid = 1'($urandom); rnd_data = 8'($urandom); end
            3: begin rnd_valid = 1'b1; rnd_data = 8'hA5; end
            default: rnd_valid = 1'b0;
        endcase
    end

    // Reference model and compare process
    bit         prev_hold = 0;
    logic [3:0] p0, p1;
    logic [TW-1:0] ptag;

    always @(negedge clk) begin
        if (!rst_n) begin
            rq.delete();
            eq.delete();
            prev_hold = 0;
        end else begin
            exp_t e;
            logic [7:0] w;
            chk("rnd_ready", rnd_ready, rq.size() < D);
            chk("busy", busy, in_valid || eq.size() != 0);
            if (rq.size() == 0) chk("in_ready_empty", in_ready, 0);
            if (flush) chk("in_ready_flush", in_ready, 0);
            if (prev_hold) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_out0", out0, p0);
                chk("hold_out1", out1, p1);
                chk("hold_tag", out_tag, ptag);
            end
            if (out_valid && out_ready) begin
                if (eq.size() == 0) begin
                    chk("spurious_out", out_valid, 0);
                end else begin
                    e = eq.pop_front();
                    chk("out_tag", out_tag, e.tag);
                    chk("out_xor", out0 ^ out1, e.v);
                    if (e.z) begin
                        chk("zero_share0", out0, e.r1);
                        chk("zero_share1", out1, e.r1);
                    end
                end
            end
            if (flush) eq.delete();
            if (in_valid && in_ready) begin
                if (rq.size() == 0) begin
                    chk("pop_empty_fifo", 1, 0);
                    w = 8'h00;
                end else begin
                    w = rq.pop_front();
                end
                e.tag = in_tag;
                e.v   = golden(in00 ^ in01, in10 ^ in11);
                e.z   = ({in00, in01, in10, in11} == 16'h0);
                e.r1  = w[7:4];
                eq.push_back(e);
            end
            if (rnd_valid && rnd_ready) rq.push_back(rnd_data);
            prev_hold = out_valid && !out_ready && !flush;
            p0 = out0;
            p1 = out1;
            ptag = out_tag;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the last accept.
    task automatic send(input int n);
        for (int k = 0; k < n; k++) begin
            int w = 0;
            in_tag = TW'($urandom);
            if ($urandom_range(3) == 0) begin
                {in00, in01, in10, in11} = 16'h0;
            end else begin
                {in00, in01, in10, in11} = 16'($urandom);
            end
            in_valid = 1'b1;
            @(negedge clk);
            while (!in_ready && w < 100) begin
                w++;
                @(negedge clk);
            end
            if (w == 100) chk("accept_timeout", 0, 1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    initial begin
        int s, c0;
        rst_n = 0; flush = 0; in_valid = 0; out_ready = 1;
        in_tag = 0; in00 = 0; in01 = 0; in10 = 0; in11 = 0;
        rnd_valid = 0; rnd_data = 0;

        chk("pin_mul_2_8", gm(4'h2, 4'h8), 4'h3);
        chk("pin_mul_3_3", gm(4'h3, 4'h3), 4'h5);
        chk("pin_mul_f_1", gm(4'hF, 4'h1), 4'hF);
        chk("pin_golden_1_0", golden(4'h1, 4'h0), 4'h9);

        #2;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_rnd_ready", rnd_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out0", out0, 0);
        chk("rst_out1", out1, 0);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_busy", busy, 0);
        chk("rst_starve", starve_cnt, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;

        // Single word A5, all-zero operands, tag 3
        in_tag = 3; in_valid = 1;
        @(negedge clk);
        chk("t1_no_word", in_ready, 0);
        rnd_mode = 3;
        @(negedge clk);
        chk("t1_before_push", in_ready, 0);
        rnd_mode = 0;
        @(negedge clk);
        chk("t1_after_push", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 0;
        @(negedge clk);
        chk("t1_lat1", out_valid, 0);
        @(negedge clk);
        chk("t1_valid", out_valid, 1);
        chk("t1_out0", out0, 4'hA);
        chk("t1_out1", out1, 4'hA);
        chk("t1_tag", out_tag, 3);

        // 200 random ops, full throughput
        rnd_mode = 1;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 c0 = cycle;
        send(200);
        chk("t2_throughput", cycle - c0, 200);

        // Backpressure for 5 cycles mid-stream
        fork
            send(30);
            begin
                repeat (6) @(posedge clk);
                #1 out_ready = 0;
                repeat (4) @(negedge clk);
                chk("t3_in_ready_drop", in_ready, 0);
                chk("t3_out_valid", out_valid, 1);
                @(posedge clk);
                #1 out_ready = 1;
            end
        join
        repeat (5) @(posedge clk);
        #1 chk("t3_drained", eq.size(), 0);

        // Randomness starvation
        @(negedge clk);
        rnd_mode = 0;
        @(posedge clk);
        #1 in_valid = 1; in_tag = 5;
        s = 0;
        @(negedge clk);
        while (in_ready && s < 20) begin
            s++;
            @(negedge clk);
        end
        s = starve_cnt;
        chk("t4_rnd_ready", rnd_ready, 1);
        repeat (10) begin
            chk("t4_in_ready", in_ready, 0);
            @(negedge clk);
        end
        chk("t4_starve", starve_cnt, 16'(s + 10));
        chk("t4_rnd_ready2", rnd_ready, 1);
        @(posedge clk);
        #1 in_valid = 0;

        // Random PRNG availability and backpressure
        @(negedge clk);
        rnd_mode = 2;
        @(posedge clk);
        #1;
        fork
            send(100);
            repeat (150) begin
                @(posedge clk);
                #1 out_ready = 1'($urandom);
            end
        join
        out_ready = 1;
        repeat (6) @(posedge clk);
        #1 chk("t5_drained", eq.size(), 0);

        // Flush with both stages valid
        @(negedge clk);
        rnd_mode = 1;
        @(posedge clk);
        #1 out_ready = 0;
        send(2);
        @(negedge clk);
        chk("t6_out_valid_pre", out_valid, 1);
        @(posedge clk);
        #1 flush = 1;
        @(negedge clk);
        chk("t6_in_ready", in_ready, 0);
        @(posedge clk);
        #1 flush = 0;
        @(negedge clk);
        chk("t6_out_valid", out_valid, 0);
        chk("t6_fifo_kept", rnd_ready, 0);
        @(posedge clk);
        #1 out_ready = 1;
        repeat (3) begin
            @(negedge clk);
            chk("t6_no_output", out_valid, 0);
        end

        // Async reset mid-stream
        @(posedge clk);
        #1;
        fork
            send(20);
            begin
                repeat (5) @(posedge clk);
                #3 rst_n = 0;
                rnd_mode = 0;
                #1;
                chk("t7_out_valid", out_valid, 0);
                chk("t7_in_ready", in_ready, 0);
                chk("t7_starve", starve_cnt, 0);
                repeat (2) @(posedge clk);
                #1 rst_n = 1;
                repeat (3) begin
                    @(negedge clk);
                    chk("t7_wait_word", in_ready, 0);
                end
                rnd_mode = 1;
            end
        join
        repeat (6) @(posedge clk);
        #1 chk("t7_drained", eq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
